// File: rtl/cntd3_pkg.sv
// -----------------------------------------------------------------------------
// cntd3_pkg
// Shared definitions for the counter family (up-counters and the cntd3
// loadable down-counter).
//   CNT_W      : default counter width
//   cnt_sel_e  : next-count select used by the count register mux
// -----------------------------------------------------------------------------
package cntd3_pkg;

    localparam int CNT_W = 3;

    // Source of the next count value.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        DEC  = 2'd2,
        WRAP = 2'd3
    } cnt_sel_e;

endpackage : cntd3_pkg

// File: rtl/cntd3_dec_w.sv
// -----------------------------------------------------------------------------
// dec_w
// Combinational W-bit decrement-by-one, built as a half-subtractor chain.
// Ports:
//   a      in  W  operand
//   diff   out W  a - 1 (modulo 2^W)
//   borrow out 1  borrow out of the MSB; high exactly when a == 0
// -----------------------------------------------------------------------------
module dec_w
    import cntd3_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // b[i] is the borrow into bit i; subtracting one means borrow-in of 1.
    logic [W:0] b;

    assign b[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_hsub
            assign diff[gi] = a[gi] ^ b[gi];
            assign b[gi+1]  = ~a[gi] & b[gi];
        end
    endgenerate

    assign borrow = b[W];

endmodule : dec_w

// File: rtl/cntd3.sv
// -----------------------------------------------------------------------------
// cntd3
// Loadable down-counter with terminal-count pulse.
// Ports:
//   clk    in  1  clock, all state on rising edge
//   reset  in  1  synchronous active-high reset
//   cnten  in  1  decrement enable
//   load   in  1  load count from ldval (wins over cnten)
//   ldval  in  W  load value
//   wrap   in  1  1: decrement at zero wraps, 0: saturate at zero
//   count  out W  current count (registered)
//   zero   out 1  count == 0 (combinational from the count register)
//   tc     out 1  one-cycle pulse when the count steps from 1 to 0
// Build option:
//   CNTD_RELOAD_EN  when defined, a reload register captures ldval on every
//                   load and is the wrap target; otherwise wrap goes to all
//                   ones.
// -----------------------------------------------------------------------------
module cntd3
    import cntd3_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cnten,
    input  logic         load,
    input  logic [W-1:0] ldval,
    input  logic         wrap,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         tc
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;
    logic         tc_reg;
    logic         tc_next;
    logic [W-1:0] dec_diff;
    logic         dec_borrow;
    logic [W-1:0] wrap_val;
    cnt_sel_e     sel;

    dec_w #(.W(W)) u_dec (
        .a      (count_reg),
        .diff   (dec_diff),
        .borrow (dec_borrow)
    );

`ifdef CNTD_RELOAD_EN
    // Periodic divider mode: wrap returns to the most recently loaded value.
    logic [W-1:0] reload_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_reg <= '0;
        end else if (load) begin
            reload_reg <= ldval;
        end
    end

    assign wrap_val = reload_reg;
`else
    assign wrap_val = '1;
`endif

    // Borrow-out flags a zero count: decrementing is replaced by wrap or hold.
    always_comb begin
        sel = HOLD;
        if (load) begin
            sel = LOAD;
        end else if (cnten) begin
            if (dec_borrow) begin
                sel = wrap ? WRAP : HOLD;
            end else begin
                sel = DEC;
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        case (sel)
            HOLD:    count_next = count_reg;
            LOAD:    count_next = ldval;
            DEC:     count_next = dec_diff;
            WRAP:    count_next = wrap_val;
            default: count_next = count_reg;
        endcase
    end

    // Only a real 1 -> 0 decrement pulses tc; loads and wraps never do.
    assign tc_next = (sel == DEC) && (dec_diff == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);
    assign tc    = tc_reg;

endmodule : cntd3

// File: tb/tb_cntd3.sv
// -----------------------------------------------------------------------------
// tb_cntd3
// Directed bench for cntd3 with a behavioural reference model and an
// every-cycle compare, plus literal expectations at key points.
// Honours CNTD_RELOAD_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_cntd3;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cnten = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] ldval = '0;
    logic         wrap = 1'b0;
    logic [W-1:0] count;
    logic         zero;
    logic         tc;

    int total  = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int m_count  = 0;
    int m_tc     = 0;
    int m_reload = 0;

    cntd3 #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .cnten (cnten),
        .load  (load),
        .ldval (ldval),
        .wrap  (wrap),
        .count (count),
        .zero  (zero),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    // Model: rules applied directly on integers, modulo 2^W.
    always @(posedge clk) begin
        if (reset) begin
            m_count  = 0;
            m_tc     = 0;
            m_reload = 0;
        end else if (load) begin
            m_count  = int'(ldval);
            m_tc     = 0;
            m_reload = int'(ldval);
        end else if (cnten) begin
            if (m_count == 0) begin
`ifdef CNTD_RELOAD_EN
                m_count = wrap ? m_reload : 0;
`else
                m_count = wrap ? (1 << W) - 1 : 0;
`endif
                m_tc = 0;
            end else begin
                m_tc    = (m_count == 1) ? 1 : 0;
                m_count = m_count - 1;
            end
        end else begin
            m_tc = 0;
        end
        chk_en = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_count", int'(count), m_count);
            chk("model_zero",  int'(zero),  (m_count == 0) ? 1 : 0);
            chk("model_tc",    int'(tc),    m_tc);
        end
    end

    // One clock cycle of stimulus; outputs are settled on return.
    task automatic cycle(input logic r, input logic ld, input int v,
                         input logic en, input logic wr);
        @(negedge clk);
        reset = r;
        load  = ld;
        ldval = W'(v);
        cnten = en;
        wrap  = wr;
        @(posedge clk);
        #1;
        $display("cycle: reset=%0d load=%0d ldval=%0d cnten=%0d wrap=%0d -> count=%0d zero=%0d tc=%0d",
                 r, ld, v, en, wr, count, zero, tc);
    endtask

    // Packed vectors {reset, load, ldval[2:0], cnten, wrap} for a mixed run.
    logic [6:0] vec [0:13] = '{
        7'b0_1_101_0_0, // load 5
        7'b0_0_000_1_1, // 4
        7'b0_0_000_0_1, // hold 4
        7'b0_0_000_1_1, // 3
        7'b0_0_000_1_1, // 2
        7'b0_0_000_1_1, // 1
        7'b0_0_000_1_1, // 0, tc
        7'b0_0_000_1_1, // wrap
        7'b0_0_000_1_0, // decrement after wrap
        7'b0_1_000_0_0, // load 0, no tc
        7'b0_0_000_1_1, // wrap from 0
        7'b0_1_001_0_0, // load 1
        7'b0_0_000_1_0, // 0, tc
        7'b0_0_000_0_0  // idle, tc clears
    };

    initial begin
        // 1: reset beats load
        cycle(1'b1, 1'b1, 5, 1'b0, 1'b0);
        chk("t1_count", int'(count), 0);
        chk("t1_zero",  int'(zero),  1);
        chk("t1_tc",    int'(tc),    0);

        // 2: load 3 then count down
        cycle(1'b0, 1'b1, 3, 1'b0, 1'b0);
        chk("t2_load", int'(count), 3);
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("t2_c2", int'(count), 2);
        chk("t2_tc2", int'(tc), 0);
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("t2_c1", int'(count), 1);
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("t2_c0", int'(count), 0);
        chk("t2_tc", int'(tc), 1);
        chk("t2_zero", int'(zero), 1);

        // 3: saturate at zero, no re-pulse
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("t3_c", int'(count), 0);
        chk("t3_tc", int'(tc), 0);
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("t3_c2", int'(count), 0);

        // 4: wrap at zero
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
`ifdef CNTD_RELOAD_EN
        chk("t4_wrap", int'(count), 3);
`else
        chk("t4_wrap", int'(count), 7);
`endif
        chk("t4_tc", int'(tc), 0);

        // 5: load wins over cnten
        cycle(1'b0, 1'b1, 2, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 6, 1'b1, 1'b0);
        chk("t5_count", int'(count), 6);
        chk("t5_tc", int'(tc), 0);

        // 6: reset drops the pending terminal count
        cycle(1'b0, 1'b1, 1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
        chk("t6_count", int'(count), 0);
        chk("t6_tc", int'(tc), 0);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("t6_tc_after", int'(tc), 0);

        // Reset clears the reload value too
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
`ifdef CNTD_RELOAD_EN
        chk("rst_reload", int'(count), 0);
`else
        chk("rst_reload", int'(count), 7);
`endif

        // Mixed directed run, checked by the model every cycle
        foreach (vec[i]) begin
            cycle(vec[i][6], vec[i][5], int'(vec[i][4:2]), vec[i][1], vec[i][0]);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_cntd3
